// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on the 50 MHz reference clock.
// Pulses the PLL reset, waits for a synchronised lock, qualifies it for a
// run of consecutive cycles, then releases the downstream reset. Failed
// attempts are retried up to MAX_RETRIES before latching FAULT. Losses of
// lock while running are counted with a saturating counter.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 8,
    parameter int CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             lock_ok,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count,
    output logic [3:0]       retry_count
);

    // Counter widths; a one-cycle parameter still needs a 1-bit counter.
    localparam int PW = (RST_PULSE_CYCLES    > 1) ? $clog2(RST_PULSE_CYCLES)    : 1;
    localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int SW = (STABLE_CYCLES       > 1) ? $clog2(STABLE_CYCLES)       : 1;

    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      sync_q;
    logic            lk_s;
    logic [PW-1:0]   pulse_cnt;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   stable_cnt;
    logic [3:0]      retry_inc;
    logic            retry_exhausted;
    logic            leave;
    logic            timeout;
    logic            lock_lost;

    // Two-flop synchroniser for the asynchronous PLL lock output.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], pll_locked};
    end

    assign lk_s = sync_q[1];

    // Failed-attempt count as it would be after this attempt, saturating at 15.
    assign retry_inc       = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;
    assign retry_exhausted = ({28'd0, retry_inc} == 32'(MAX_RETRIES));
    assign timeout         = (state == S_WAIT_LOCK) && !lk_s && (timer == TIMER_LAST);
    assign lock_lost       = (state == S_RUN) && !lk_s;

    // Any state change (or a restart, which may re-enter RESET_PLL) restarts
    // the per-state counters from zero.
    assign leave = restart || (next_state != state);

    // State register.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET_PLL;
        else        state <= next_state;
    end

    // Next-state logic; restart overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET_PLL: begin
                if (pulse_cnt == PULSE_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk_s)         next_state = S_STABILIZE;
                else if (timeout) next_state = retry_exhausted ? S_FAULT : S_RESET_PLL;
            end
            S_STABILIZE: begin
                // A dropout restarts the wait but does not count as a retry.
                if (!lk_s)                           next_state = S_WAIT_LOCK;
                else if (stable_cnt == STABLE_LAST)  next_state = S_RUN;
            end
            S_RUN: begin
                if (!lk_s) next_state = S_RESET_PLL;
            end
            S_FAULT: begin
                next_state = S_FAULT;
            end
            default: next_state = S_RESET_PLL;
        endcase
        if (restart) next_state = S_RESET_PLL;
    end

    // Moore output decode; reset lands in RESET_PLL so outputs follow rst_n at once.
    always_comb begin
        pll_rst   = 1'b0;
        sys_rst_n = 1'b0;
        lock_ok   = 1'b0;
        fault     = 1'b0;
        case (state)
            S_RESET_PLL: pll_rst = 1'b1;
            S_RUN: begin
                sys_rst_n = 1'b1;
                lock_ok   = 1'b1;
            end
            S_FAULT: begin
                pll_rst = 1'b1;
                fault   = 1'b1;
            end
            default: ;
        endcase
    end

    // PLL reset pulse length counter.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                                 pulse_cnt <= '0;
        else if ((state == S_RESET_PLL) && !leave)  pulse_cnt <= pulse_cnt + 1'b1;
        else                                        pulse_cnt <= '0;
    end

    // Lock wait timer.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                                 timer <= '0;
        else if ((state == S_WAIT_LOCK) && !leave)  timer <= timer + 1'b1;
        else                                        timer <= '0;
    end

    // Consecutive-lock counter used to qualify stability.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                                 stable_cnt <= '0;
        else if ((state == S_STABILIZE) && !leave)  stable_cnt <= stable_cnt + 1'b1;
        else                                        stable_cnt <= '0;
    end

    // Failed attempts since the last successful run or restart.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                                          retry_count <= 4'd0;
        else if (restart)                                    retry_count <= 4'd0;
        else if ((next_state == S_RUN) && (state != S_RUN))  retry_count <= 4'd0;
        else if (timeout)                                    retry_count <= retry_inc;
    end

    // Lock losses while running; counted even when a restart lands in the same cycle.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                            loss_count <= '0;
        else if (lock_lost && !(&loss_count))  loss_count <= loss_count + 1'b1;
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock
// patterns, checked every cycle against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;
    localparam int CW = 8;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic          refclk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          restart;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          lock_ok;
    logic          fault;
    logic [CW-1:0] loss_count;
    logic [3:0]    retry_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .STABLE_CYCLES      (ST),
        .MAX_RETRIES        (MR),
        .CNT_W              (CW)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_ok    (lock_ok),
        .fault      (fault),
        .loss_count (loss_count),
        .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles elapsed in that phase.
    bit m_s1, m_lk;
    int m_ph, m_el, m_retry, m_loss;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b0; m_lk <= 1'b0;
            m_ph <= PH_RST; m_el <= 0; m_retry <= 0; m_loss <= 0;
        end else begin
            int ph, el, rt, ls;
            ph = m_ph; el = m_el + 1; rt = m_retry; ls = m_loss;
            case (m_ph)
                PH_RST:  if (m_el + 1 == RP) begin ph = PH_WAIT; el = 0; end
                PH_WAIT: begin
                    if (m_lk) begin ph = PH_STAB; el = 0; end
                    else if (m_el + 1 == TO) begin
                        rt = (rt < 15) ? rt + 1 : 15;
                        ph = (rt == MR) ? PH_FAULT : PH_RST;
                        el = 0;
                    end
                end
                PH_STAB: begin
                    if (!m_lk) begin ph = PH_WAIT; el = 0; end
                    else if (m_el + 1 == ST) begin ph = PH_RUN; el = 0; rt = 0; end
                end
                PH_RUN: if (!m_lk) begin
                    ph = PH_RST; el = 0;
                    if (ls < (1 << CW) - 1) ls = ls + 1;
                end
                default: el = 0;
            endcase
            if (restart) begin ph = PH_RST; el = 0; rt = 0; end
            m_ph <= ph; m_el <= el; m_retry <= rt; m_loss <= ls;
            m_s1 <= pll_locked; m_lk <= m_s1;
        end
    end

    logic [15:0] dut_vec, mdl_vec;
    assign dut_vec = {pll_rst, sys_rst_n, lock_ok, fault, retry_count, loss_count};
    assign mdl_vec = {(m_ph == PH_RST) || (m_ph == PH_FAULT), m_ph == PH_RUN, m_ph == PH_RUN,
                      m_ph == PH_FAULT, 4'(m_retry), 8'(m_loss)};

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge refclk) if (chk_on) chk("cyc", dut_vec, mdl_vec);

    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic wait_ph(input string tag, input int ph, input int bound);
        int k;
        k = 0;
        while (m_ph != ph && k < bound) begin tick(); k++; end
        chk(tag, m_ph, ph);
    endtask

    task automatic wait_lock(input string tag, input int bound);
        int k;
        k = 0;
        while (!lock_ok && k < bound) begin tick(); k++; end
        chk(tag, lock_ok, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p;
        logic [63:0] obs, expv;
        rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
        repeat (3) @(negedge refclk);
        chk_on = 1'b1;
        chk("rst_outs", {pll_rst, sys_rst_n, lock_ok, fault}, 4'b1000);
        chk("rst_cnts", {retry_count, loss_count}, 0);

        // Nominal lock
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin tick(); n++; if (!pll_rst) break; end
        chk("pulse_len", n, RP);
        repeat (10 - RP) tick();
        pll_locked = 1'b1;
        tick();                                   // edge E samples the lock
        n = 0;
        for (int i = 0; i < 50; i++) begin tick(); n++; if (sys_rst_n) break; end
        chk("lock_lat", n, ST + 2);
        chk("run_outs", {lock_ok, fault, pll_rst}, 3'b100);
        chk("run_retry", retry_count, 0);

        // Loss in RUN, repeated to saturation
        for (int k = 0; k < 256; k++) begin
            pll_locked = 1'b0;
            tick();
            if (k == 0) chk("loss_e0", sys_rst_n, 1);
            tick();
            if (k == 0) chk("loss_e1", sys_rst_n, 1);
            tick();
            if (k == 0) begin
                chk("loss_e2", {sys_rst_n, pll_rst}, 2'b01);
                chk("loss_cnt1", loss_count, 1);
                n = 1;
                for (int i = 0; i < 20; i++) begin tick(); if (!pll_rst) break; n++; end
                chk("loss_pulse", n, RP);
            end
            pll_locked = 1'b1;
            wait_lock("relock", 60);
        end
        chk("loss_sat", loss_count, 255);

        // Retry then fault
        pll_locked = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        obs = '0; expv = '0;
        obs[0] = pll_rst;
        for (int i = 1; i < 60; i++) begin
            tick();
            obs[i] = pll_rst;
            if (i == RP + TO) chk("retry_first", retry_count, 1);
            if (i == 2 * (RP + TO) - 1) chk("fault_pre", fault, 0);
            if (i == 2 * (RP + TO)) chk("fault_set", fault, 1);
        end
        for (int i = 0; i < 60; i++)
            expv[i] = (i < RP) || (i >= RP + TO && i < 2 * RP + TO) || (i >= 2 * (RP + TO));
        chk("retry_pulses", obs, expv);
        chk("fault_hold", {fault, pll_rst, sys_rst_n, lock_ok}, 4'b1100);
        chk("fault_retry", retry_count, MR);

        // Restart out of FAULT
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_outs", {fault, pll_rst}, 2'b01);
        chk("rs_retry", retry_count, 0);
        chk("rs_loss", loss_count, 255);

        // Unstable lock: one timeout first so retry_count is non-zero
        repeat (RP + TO + RP) tick();
        chk("unst_pre_retry", retry_count, 1);
        pll_locked = 1'b1;
        wait_ph("unst_stab", PH_STAB, 10);
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();                                   // edge D samples the dropout
        pll_locked = 1'b1;
        n = 0; p = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (pll_rst) p++;
            if (n == 2) chk("unst_retry", retry_count, 1);
            if (lock_ok) break;
        end
        chk("unst_lat", n, 3 + ST);
        chk("unst_nopulse", p, 0);

        // Glitch in WAIT_LOCK
        pll_locked = 1'b0;
        wait_ph("gl_wait", PH_WAIT, 20);
        pll_locked = 1'b1;
        tick();                                   // edge G
        pll_locked = 1'b0;
        n = 0; p = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (sys_rst_n) p++;
            if (pll_rst) break;
        end
        chk("gl_timeout", n, 3 + TO);
        chk("gl_norun", p, 0);

        // Async reset mid-STABILIZE
        pll_locked = 1'b1;
        wait_ph("ar_stab", PH_STAB, 20);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_outs", {pll_rst, sys_rst_n, lock_ok, fault}, 4'b1000);
        chk("ar_cnts", {retry_count, loss_count}, 0);
        @(negedge refclk);
        rst_n = 1'b1;

        // Randomized lock patterns with occasional restarts
        for (int blk = 0; blk < 8; blk++) begin
            int rate;
            rate = $urandom_range(3, 40);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, rate - 1) == 0) pll_locked = ~pll_locked;
                restart = ($urandom_range(0, 149) == 0);
                tick();
            end
        end
        restart = 1'b0;
        tick();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock sequencer on the far side of the PLL wrapper. It drives the PLL's active-high `rst`, watches its asynchronous `locked` output, and qualifies lock stability before releasing the downstream system reset. It retries a PLL that fails to lock, counts lock losses, and latches a fault after repeated failures. It runs on the 50 MHz reference clock, which is independent of the PLL output.

## Interface
- `RST_PULSE_CYCLES`, default 16: length of each `pll_rst` pulse, in cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 50000: wait for lock per attempt (1 ms at 50 MHz).
- `STABLE_CYCLES`, default 1024: consecutive lock cycles required before release.
- `MAX_RETRIES`, default 8: failed attempts allowed before FAULT (≥1).
- `CNT_W`, default 8: width of `loss_count`.

Ports:
- `refclk` in 1: reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`, asynchronous; synchronised internally.
- `restart` in 1: synchronous single-cycle request to restart the sequence.
- `pll_rst` out 1: drives PLL `rst`, active-high.
- `sys_rst_n` out 1: downstream reset, active-low; 1 only in RUN.
- `lock_ok` out 1: 1 only in RUN.
- `fault` out 1: 1 only in FAULT.
- `loss_count` out CNT_W: number of RUN→lock-loss events, saturating.
- `retry_count` out 4: failed lock attempts since the last RUN or restart.

## Operation
- **Synchroniser:** two-flop synchroniser on `pll_locked` produces `lk_s`. Reset value is 0.
- **Output decode:** outputs are Moore decodes of the state register; no combinational path from inputs.
- **States:** RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT.
- **RESET_PLL:**
  - `pll_rst`=1.
  - Counts RST_PULSE_CYCLES cycles, then goes to WAIT_LOCK with the timer cleared.
- **WAIT_LOCK:**
  - `pll_rst`=0; the timer increments each cycle.
  - If `lk_s`=1, go to STABILIZE with the stable counter cleared.
  - Otherwise, when the timer reaches LOCK_TIMEOUT_CYCLES-1, increment `retry_count`. If the new count equals MAX_RETRIES, go to FAULT; else go to RESET_PLL.
- **STABILIZE:**
  - The counter increments while `lk_s`=1.
  - If `lk_s`=0, go back to WAIT_LOCK with the timer cleared. This is not a retry.
  - When the counter reaches STABLE_CYCLES-1 with `lk_s`=1, go to RUN.
- **RUN:**
  - `sys_rst_n`=1, `lock_ok`=1.
  - Entering RUN clears `retry_count`.
  - If `lk_s`=0, `loss_count` increments (saturating at all-ones) and the FSM goes to RESET_PLL.
- **FAULT:**
  - `pll_rst`=1, `sys_rst_n`=0, `fault`=1.
  - Held until `restart` or `rst_n`.
- **restart:** when `restart`=1, the FSM goes to RESET_PLL from any state, with counters cleared and `retry_count` cleared. `loss_count` is kept.
  - `restart` beats any other transition in the same cycle.
  - A lock loss in RUN that coincides with `restart` still increments `loss_count`.
- **Reset (`rst_n`=0):**
  - State goes to RESET_PLL. All counters, `loss_count`, `retry_count` and the synchroniser go to 0.
  - Outputs during reset: `pll_rst`=1, `sys_rst_n`=0, `lock_ok`=0, `fault`=0.
  - Assertion in the middle of any state takes effect immediately (asynchronously).
- **Counter widths:** the timer is sized by `$clog2(LOCK_TIMEOUT_CYCLES)`; the other counters are sized likewise from their parameters. `retry_count` saturates at 15.

## Timing
- **First lock attempt:** after `rst_n` deasserts, `pll_rst` stays high for exactly RST_PULSE_CYCLES rising edges.
- **Lock to STABILIZE:** `pll_locked` high meeting setup before edge E gives `lk_s`=1 after E+1 and state=STABILIZE after E+2.
- **Lock to release:** `sys_rst_n` rises STABLE_CYCLES edges after STABILIZE is entered. Best-case latency from `pll_locked` to `sys_rst_n` is STABLE_CYCLES+2 edges.
- **Loss of lock:** `pll_locked` falling before edge E gives `sys_rst_n`=0 and `pll_rst`=1 after E+2.
- **Timeout:** the timeout fires on exactly the LOCK_TIMEOUT_CYCLES-th cycle in WAIT_LOCK.
- **Restart:** `restart` sampled at edge E means state=RESET_PLL after E.

## Test plan
Parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2.

1. **Nominal lock:** release `rst_n`; raise `pll_locked` 10 cycles later -> `pll_rst` high for 4 cycles; `sys_rst_n`=1 and `lock_ok`=1 exactly 10 edges after `pll_locked` rises; `retry_count`=0.
2. **Retry then fault:** hold `pll_locked`=0 -> two `pll_rst` pulses of 4 cycles separated by 20 low cycles; then `fault`=1, `retry_count`=2, `pll_rst` stuck at 1.
3. **Unstable lock:** in STABILIZE, drop `pll_locked` for 1 cycle after 5 stable cycles -> back to WAIT_LOCK, no `pll_rst` pulse, `retry_count` unchanged; RUN is reached only after 8 new consecutive lock cycles.
4. **Loss in RUN:** in RUN, drop `pll_locked` -> `sys_rst_n`=0 two edges later; `loss_count` goes 0→1; 4-cycle `pll_rst` pulse. Repeat 256 times with CNT_W=8 -> `loss_count` saturates at 255.
5. **Restart and async reset:** pulse `restart` in FAULT -> RESET_PLL on the next edge; `fault`=0; `retry_count`=0; `loss_count` kept. Assert `rst_n` mid-STABILIZE -> outputs go to reset values immediately; `loss_count`=0.
6. **Glitch filtering:** a 1-cycle `pll_locked` pulse in WAIT_LOCK -> enters and leaves STABILIZE; `sys_rst_n` never rises.
